// File: rtl/ecc_point_decrypt_pkg.sv
// Shared parameters, FSM encoding and op-select encoding for the EC-ElGamal decryptor.
// LAT is the fixed start-edge-to-done latency in clock cycles.
package ecc_point_decrypt_pkg;
  localparam int M   = 4;
  localparam int K   = 4;
  localparam int LAT = 2 + (2 * K + 1) * (M + 3);
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int IW  = (M > 2) ? $clog2(M - 1) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, DBL, ADD, SUB, SETUP, INV, LAMBDA, X3, Y3, DONE
  } state_t;

  typedef enum logic {OP_DBL, OP_ADD} op_t;
endpackage

// File: rtl/gf2m_mul.sv
// Combinational GF(2^M) multiplier, MSB-first shift-and-add with reduction by poly.
module gf2m_mul
  import ecc_point_decrypt_pkg::*;
(
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] poly,
  output logic [M-1:0] p
);
  logic [M-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? poly : '0);
      if (b[i]) acc = acc ^ a;
    end
    p = acc;
  end
endmodule

// File: rtl/ecc_point_decrypt.sv
// Sequential EC-ElGamal decryptor: M = C2 - d*C1 over GF(2^M), constant-time double-and-add.
// Handshake: start is sampled only in IDLE; done pulses one cycle with results valid, busy drops that same cycle.
module ecc_point_decrypt
  import ecc_point_decrypt_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [K-1:0] d,
  input  logic [M-1:0] c1x,
  input  logic [M-1:0] c1y,
  input  logic         c1_inf,
  input  logic [M-1:0] c2x,
  input  logic [M-1:0] c2y,
  input  logic         c2_inf,
  input  logic [M-1:0] a,
  input  logic [M:0]   f,
  output logic [M-1:0] mx,
  output logic [M-1:0] my,
  output logic         m_inf,
  output logic         busy,
  output logic         done,
  output state_t       dbg_state,
  output state_t       dbg_phase
);
  localparam logic [IW-1:0] INV_LAST = IW'(M - 2);
  localparam logic [M-1:0]  GF_ONE   = M'(1);

  state_t state, next_state, phase;
  op_t mode;
  logic [KW-1:0] bit_idx;
  logic [IW-1:0] inv_cnt;
  logic [K-1:0] d_r;
  logic [M-1:0] c1x_r, c1y_r, c2x_r, c2y_r, a_r, poly_r;
  logic c1inf_r, c2inf_r;
  logic [M-1:0] qx, qy;
  logic qinf;
  logic [M-1:0] num, den, r, lam, x3r;
  logic [M-1:0] x1, y1, x2, y2;
  logic inf1, inf2;
  logic setup_dbl;
  logic [M-1:0] setup_num, setup_den;
  logic [M-1:0] ma0, mb0, ma1, mb1, p0, p1, y3;
  logic [M-1:0] rx, ry;
  logic rinf;
  logic f_unused;

  assign f_unused  = f[M];
  assign dbg_state = state;
  assign dbg_phase = phase;

  gf2m_mul u_mul0 (.a(ma0), .b(mb0), .poly(poly_r), .p(p0));
  gf2m_mul u_mul1 (.a(ma1), .b(mb1), .poly(poly_r), .p(p1));

  // Operands: P1 + P2 for DBL/ADD use Q (and C1); the final step is C2 + (-Q).
  always_comb begin
    x1 = qx;    y1 = qy;    inf1 = qinf;
    x2 = c1x_r; y2 = c1y_r; inf2 = c1inf_r;
    if (phase == SUB) begin
      x1 = c2x_r; y1 = c2y_r;   inf1 = c2inf_r;
      x2 = qx;    y2 = qx ^ qy; inf2 = qinf;
    end
  end

  // Equal operands in an add are steered onto the doubling formula at SETUP.
  always_comb begin
    setup_dbl = (phase == DBL) || ((x1 == x2) && (y1 == y2));
    setup_num = setup_dbl ? y1 : (y1 ^ y2);
    setup_den = setup_dbl ? x1 : (x1 ^ x2);
  end

  always_comb begin
    ma0 = r;
    mb0 = r;
    ma1 = p0;
    mb1 = den;
    case (state)
      LAMBDA: begin ma0 = num; mb0 = r; end
      X3:     begin ma0 = lam; mb0 = lam; end
      Y3: begin
        if (mode == OP_DBL) begin
          ma0 = lam ^ GF_ONE; mb0 = x3r;
        end else begin
          ma0 = lam; mb0 = x1 ^ x3r;
        end
        ma1 = x1;
        mb1 = x1;
      end
      default: ;
    endcase
    y3 = (mode == OP_DBL) ? (p1 ^ p0) : (p0 ^ x3r ^ y1);
  end

  // Special cases override the arithmetic result at Y3 writeback.
  always_comb begin
    rx = x3r;
    ry = y3;
    rinf = 1'b0;
    if (phase == DBL) begin
      rinf = inf1 || (x1 == '0);
    end else if (inf1) begin
      rx = x2; ry = y2; rinf = inf2;
    end else if (inf2) begin
      rx = x1; ry = y1;
    end else if (x1 == x2) begin
      rinf = (y1 != y2) || (x1 == '0);
    end
    if (rinf) begin
      rx = '0;
      ry = '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = SETUP;
      SETUP:   next_state = INV;
      INV:     if (inv_cnt == INV_LAST) next_state = LAMBDA;
      LAMBDA:  next_state = X3;
      X3:      next_state = Y3;
      Y3:      next_state = (phase == SUB) ? DONE : SETUP;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase <= DBL;   mode <= OP_ADD;
      bit_idx <= '0;  inv_cnt <= '0;  d_r <= '0;
      c1x_r <= '0;    c1y_r <= '0;    c1inf_r <= 1'b0;
      c2x_r <= '0;    c2y_r <= '0;    c2inf_r <= 1'b0;
      a_r <= '0;      poly_r <= '0;
      qx <= '0;       qy <= '0;       qinf <= 1'b1;
      num <= '0;      den <= '0;      r <= '0;
      lam <= '0;      x3r <= '0;
      mx <= '0;       my <= '0;       m_inf <= 1'b0;
      busy <= 1'b0;   done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          d_r <= d;
          c1x_r <= c1x; c1y_r <= c1y; c1inf_r <= c1_inf;
          c2x_r <= c2x; c2y_r <= c2y; c2inf_r <= c2_inf;
          a_r <= a;     poly_r <= f[M-1:0];
          qx <= '0;     qy <= '0;     qinf <= 1'b1;
          phase <= DBL;
          bit_idx <= KW'(K - 1);
          busy <= 1'b1;
        end
        SETUP: begin
          mode <= setup_dbl ? OP_DBL : OP_ADD;
          num <= setup_num;
          den <= setup_den;
          r <= setup_den;
          inv_cnt <= '0;
        end
        // Itoh-Tsujii: r <- r^2*u for all but the last step, which is a plain square.
        INV: begin
          r <= (inv_cnt == INV_LAST) ? p0 : p1;
          inv_cnt <= inv_cnt + 1'b1;
        end
        LAMBDA: lam <= (mode == OP_DBL) ? (p0 ^ x1) : p0;
        X3: x3r <= p0 ^ lam ^ a_r ^ ((mode == OP_ADD) ? (x1 ^ x2) : '0);
        Y3: begin
          case (phase)
            DBL: begin
              qx <= rx; qy <= ry; qinf <= rinf;
              phase <= ADD;
            end
            ADD: begin
              if (d_r[bit_idx]) begin
                qx <= rx; qy <= ry; qinf <= rinf;
              end
              if (bit_idx == '0) begin
                phase <= SUB;
              end else begin
                phase <= DBL;
                bit_idx <= bit_idx - 1'b1;
              end
            end
            default: begin
              qx <= rx; qy <= ry; qinf <= rinf;
            end
          endcase
        end
        DONE: begin
          mx <= qx;
          my <= qy;
          m_inf <= qinf;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_point_decrypt.sv
// Randomized scoreboard bench for ecc_point_decrypt with a field-level reference model.
module tb_ecc_point_decrypt;
  import ecc_point_decrypt_pkg::*;

  typedef struct packed {
    logic         inf;
    logic [M-1:0] x;
    logic [M-1:0] y;
  } pt_t;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [K-1:0] d;
  logic [M-1:0] c1x, c1y, c2x, c2y, a;
  logic         c1_inf, c2_inf;
  logic [M:0]   f;
  logic [M-1:0] mx, my;
  logic         m_inf, busy, done;
  state_t       dbg_state, dbg_phase;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  pt_t  exp_q[$];
  int   exp_cyc_q[$];
  pt_t  mon_e;
  int   mon_c;

  ecc_point_decrypt dut (
    .clock(clock), .reset_n(reset_n), .start(start), .d(d),
    .c1x(c1x), .c1y(c1y), .c1_inf(c1_inf),
    .c2x(c2x), .c2y(c2y), .c2_inf(c2_inf),
    .a(a), .f(f), .mx(mx), .my(my), .m_inf(m_inf),
    .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: carry-less product then long-division reduction
  function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y,
                                        input logic [M:0] ff);
    logic [2*M-2:0] prod;
    prod = '0;
    for (int i = 0; i < M; i++)
      if (y[i]) prod = prod ^ ((2*M-1)'(x) << i);
    for (int i = 2*M-2; i >= M; i--)
      if (prod[i]) prod = prod ^ ((2*M-1)'(ff) << (i - M));
    return prod[M-1:0];
  endfunction

  function automatic logic [M-1:0] ginv(input logic [M-1:0] u, input logic [M:0] ff);
    for (int v = 1; v < (1 << M); v++)
      if (gmul(u, M'(v), ff) == M'(1)) return M'(v);
    return '0;
  endfunction

  function automatic pt_t pt_inf();
    pt_t r;
    r = '0;
    r.inf = 1'b1;
    return r;
  endfunction

  function automatic pt_t pt_dbl(input pt_t p, input logic [M-1:0] aa, input logic [M:0] ff);
    pt_t r;
    logic [M-1:0] lam;
    if (p.inf || p.x == '0) return pt_inf();
    lam = p.x ^ gmul(p.y, ginv(p.x, ff), ff);
    r.inf = 1'b0;
    r.x = gmul(lam, lam, ff) ^ lam ^ aa;
    r.y = gmul(p.x, p.x, ff) ^ gmul(lam ^ M'(1), r.x, ff);
    return r;
  endfunction

  function automatic pt_t pt_add(input pt_t p, input pt_t q, input logic [M-1:0] aa,
                                 input logic [M:0] ff);
    pt_t r;
    logic [M-1:0] lam;
    if (p.inf) return q;
    if (q.inf) return p;
    if (p.x == q.x) return (p.y == q.y) ? pt_dbl(p, aa, ff) : pt_inf();
    lam = gmul(p.y ^ q.y, ginv(p.x ^ q.x, ff), ff);
    r.inf = 1'b0;
    r.x = gmul(lam, lam, ff) ^ lam ^ p.x ^ q.x ^ aa;
    r.y = gmul(lam, p.x ^ r.x, ff) ^ r.x ^ p.y;
    return r;
  endfunction

  function automatic pt_t ref_decrypt(input logic [K-1:0] dd, input pt_t c1, input pt_t c2,
                                      input logic [M-1:0] aa, input logic [M:0] ff);
    pt_t q;
    q = pt_inf();
    for (int i = K - 1; i >= 0; i--) begin
      q = pt_dbl(q, aa, ff);
      if (dd[i]) q = pt_add(q, c1, aa, ff);
    end
    if (!q.inf) q.y = q.x ^ q.y;
    return pt_add(c2, q, aa, ff);
  endfunction

  function automatic pt_t mkpt(input int x, input int y, input bit inf);
    pt_t r;
    r.inf = inf;
    r.x = M'(x);
    r.y = M'(y);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: call at a negedge; start is sampled at the following posedge
  task automatic issue(input logic [K-1:0] dd, input pt_t c1, input pt_t c2,
                       input logic [M-1:0] aa, input logic [M:0] ff,
                       input bit push, input pt_t e);
    d = dd; a = aa; f = ff;
    c1x = c1.x; c1y = c1.y; c1_inf = c1.inf;
    c2x = c2.x; c2y = c2.y; c2_inf = c2.inf;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1 + LAT);
    end
    @(negedge clock);
    start = 1'b0;
    d = K'($urandom); a = M'($urandom); f = (M+1)'($urandom);
    c1x = M'($urandom); c1y = M'($urandom); c1_inf = 1'($urandom);
    c2x = M'($urandom); c2y = M'($urandom); c2_inf = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy=%0b required=0 after %0d cycles", busy, n);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Monitor/scoreboard
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("done_cycle", cyc, mon_c);
        check("busy_at_done", busy, 1'b0);
        check("m_inf", m_inf, mon_e.inf);
        if (!mon_e.inf) begin
          check("mx", mx, mon_e.x);
          check("my", my, mon_e.y);
        end
      end
    end
  end

  logic [M:0] polys [3];
  pt_t        p35, p96, p07, c1r, c2r, e;
  logic [M:0] ff;
  logic [M-1:0] aa;
  logic [K-1:0] dd;
  int         s0;

  initial begin
    polys[0] = 5'b10011; polys[1] = 5'b11001; polys[2] = 5'b11111;
    p35 = mkpt(3, 5, 0); p96 = mkpt(9, 6, 0); p07 = mkpt(0, 7, 0);
    reset_n = 1'b0; start = 1'b0; d = '0; a = '0; f = '0;
    c1x = '0; c1y = '0; c1_inf = 1'b0; c2x = '0; c2y = '0; c2_inf = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mx", mx, 0);
    check("rst_my", my, 0);
    check("rst_m_inf", m_inf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases with hand-derived results
    issue(0, p35, p96, 0, polys[0], 1, mkpt(9, 6, 0));
    check("busy_after_start", busy, 1'b1);
    wait_idle();
    issue(1, p35, p35, 0, polys[0], 1, pt_inf());
    wait_idle();
    issue(2, p07, p96, 0, polys[0], 1, mkpt(9, 6, 0));
    wait_idle();
    issue(3, p07, p07, 0, polys[0], 1, pt_inf());
    wait_idle();
    issue(0, p35, pt_inf(), 0, polys[0], 1, pt_inf());
    wait_idle();
    issue(15, pt_inf(), p96, 0, polys[0], 1, mkpt(9, 6, 0));
    wait_idle();

    // Handshake: starts 10 and 65 cycles in are ignored, one at 66 is accepted
    s0 = cyc;
    issue(5, p35, p96, 4'h1, polys[0], 1, ref_decrypt(5, p35, p96, 4'h1, polys[0]));
    wait_until(s0 + 10);
    issue(9, p07, p35, 4'h2, polys[1], 0, '0);
    wait_until(s0 + 65);
    issue(6, p96, p07, 4'h3, polys[2], 0, '0);
    issue(11, p96, p35, 4'h7, polys[0], 1, ref_decrypt(11, p96, p35, 4'h7, polys[0]));
    wait_idle();

    // Reset mid-operation: abort with no done pulse
    s0 = cyc;
    issue(13, p35, p96, 4'h5, polys[0], 0, '0);
    wait_until(s0 + 30);
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mx", mx, 0);
    check("abort_my", my, 0);
    check("abort_m_inf", m_inf, 0);
    check("abort_state", dbg_state, IDLE);
    reset_n = 1'b1;
    repeat (80) @(negedge clock);
    check("abort_idle", busy, 0);

    // Randomized back-to-back operations
    for (int n = 0; n < 40; n++) begin
      wait_idle();
      ff = polys[$urandom_range(0, 2)];
      aa = M'($urandom);
      dd = K'($urandom_range(0, (1 << K) - 1));
      c1r = mkpt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) c1r.x = '0;
      case ($urandom_range(0, 4))
        0: c2r = c1r;
        1: begin c2r = c1r; c2r.y = c1r.x ^ c1r.y; end
        2: c2r = mkpt(c1r.x, $urandom_range(0, 15), 0);
        default: c2r = mkpt($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 9) == 0);
      endcase
      e = ref_decrypt(dd, c1r, c2r, aa, ff);
      issue(dd, c1r, c2r, aa, ff, 1, e);
    end
    wait_idle();
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecc_point_decrypt.md
Name: ecc_point_decrypt

Overview:
- Sequential EC-ElGamal decryptor over GF(2^M), curve y^2 + xy = x^3 + a·x^2 + b.
- Computes message point Mpt = C2 − d·C1 from ciphertext (C1, C2) and private scalar d.
- Counterpart of the combinational scalar-multiply/encrypt path: it recovers the message point that path hides.
- Iterative, constant-time double-and-add using one shared field datapath; start/busy/done handshake.

Parameters:
- M, 4, field degree; coordinates and a are M bits.
- K, 4, scalar width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- d  in  K  private scalar.
- c1x, c1y  in  M  ciphertext point C1.
- c1_inf  in  1  C1 is the point at infinity O.
- c2x, c2y  in  M  ciphertext point C2.
- c2_inf  in  1  C2 is O.
- a  in  M  curve coefficient a.
- f  in  M+1  reduction polynomial, bit M set (e.g. 10011 = x^4+x+1).
- mx, my  out  M  result point.
- m_inf  out  1  result is O.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when mx/my/m_inf are valid.

Behaviour:
- Reset (reset_n=0 at an edge): FSM→IDLE; mx=my=0, m_inf=0, busy=0, done=0; any operation in progress is aborted, no done pulse.
- IDLE + start=1: latch d, C1, C2, a, f; accumulator Q=O; busy=1 from the next cycle.
- start while busy: ignored. Inputs may change after the latch edge.
- Scalar loop: bits d[K-1] down to d[0]:
  - Q ← 2Q.
  - Always compute T = Q + C1; commit Q ← T only if the bit is 1, otherwise discard (dummy add).
- Final step: Mpt = C2 + (−Q), where −(x,y) = (x, x⊕y) and −O = O.
- Point op microsequence, M+3 cycles, fixed: SETUP (numerator/denominator), INV (M−1 cycles), LAMBDA, X3, Y3.
  - Addition: λ = (y1⊕y2)/(x1⊕x2); x3 = λ²⊕λ⊕x1⊕x2⊕a; y3 = λ(x1⊕x3)⊕x3⊕y1.
  - Doubling: λ = x1 ⊕ y1/x1; x3 = λ²⊕λ⊕a; y3 = x1² ⊕ (λ⊕1)·x3.
- Inversion of u by Itoh–Tsujii:
  - r=u, then r←r²·u repeated M−2 times, then r←r² (u^(2^M−2)).
  - u=0 yields 0; the result is then overridden by the special-case rules below.
- Special cases, resolved at Y3 writeback; cycle count is unchanged:
  - O+P = P; P+O = P.
  - x1=x2 and y1=y2 → take the doubling result.
  - x1=x2 and y1≠y2 → O.
  - Doubling of O or of a point with x=0 → O.
- Latency: done asserts exactly LAT = 2 + (2K+1)(M+3) cycles after the start edge (65 for M=4, K=4), independent of d and the data.
- Outputs update on the done cycle and hold until the next done or reset.
- busy falls in the same cycle done is high; a start in that cycle is ignored; a new start is accepted from the following cycle.
- Arithmetic: GF(2^M) add = XOR; multiply = shift-and-add with conditional XOR of f[M-1:0] on overflow; all results M bits.

Decomposition:
- Shared package holds:
  - parameters M, K;
  - FSM state encoding: IDLE, LOAD, DBL, ADD, SUB, SETUP, INV, LAMBDA, X3, Y3, DONE;
  - derived constant LAT;
  - op-select encoding (OP_DBL, OP_ADD).
- One sub-module: gf2m_mul, a combinational M-bit multiplier with f input. It is shared by squaring, inversion and λ/x3/y3 steps; instantiate once or twice, no more.
- The FSM and point-op sequencer stay in ecc_point_decrypt.

Test Plan:
- Scalar zero: d=0, C1=(3,5), C2=(9,6), f=10011, a=0 → done at cycle 65; mx=9, my=6, m_inf=0.
- Self-cancel: d=1, C1=C2=(3,5) → m_inf=1 (C2−C1=O).
- Order-2 point: C1=(0,7), d=2 → 2C1=O so result=C2=(9,6). Same C1 with d=3 and C2=(0,7) → m_inf=1.
- Infinity input: c2_inf=1, d=0 → m_inf=1. c1_inf=1, d=15, C2=(9,6) → (9,6).
- Handshake: pulse start again at cycles 10 and 65 → no restart, exactly one done at cycle 65. A start at cycle 66 → second done at cycle 131.
- Reset mid-operation: reset_n=0 at cycle 30 → next cycle busy=0, done=0, outputs 0; no done pulse appears for the aborted op.
